// File: rtl/l1i_cache.sv
// Direct-mapped, read-only L1 instruction cache with 32-byte lines and zero-cycle hits.
// Optional macro L1I_CRITICAL_WORD_BYPASS_EN forwards the requested word during the fill cycle.
module l1i_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic [31:0]  mem_address,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         l1i_hit,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tags  [SETS];
  logic [255:0]       lines [SETS];
  logic [26:0]        fill_line;
  logic               miss;

  logic [S_INDEX-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         wsel;
  logic [S_INDEX-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               lookup_hit;
  logic               idle_hit;
  logic               fill_done;
  logic               bypass;
  logic               unused_addr_bits;

  assign wsel             = mem_address[4:2];
  assign idx              = mem_address[S_INDEX+4:5];
  assign tag              = mem_address[31:S_INDEX+5];
  assign fill_idx         = fill_line[S_INDEX-1:0];
  assign fill_tag         = fill_line[26:S_INDEX];
  assign unused_addr_bits = ^mem_address[1:0];

  assign lookup_hit = valid[idx] && (tags[idx] == tag);
  assign idle_hit   = (state == IDLE) && mem_read && lookup_hit;
  assign fill_done  = (state == FILL) && pmem_resp;

`ifdef L1I_CRITICAL_WORD_BYPASS_EN
  // Forward the critical word straight off the fill bus when the CPU still wants this line.
  assign bypass = fill_done && mem_read && (mem_address[31:5] == fill_line);
`else
  assign bypass = 1'b0;
`endif

  assign mem_resp     = idle_hit || bypass;
  assign l1i_hit      = mem_resp && !miss;
  assign pmem_read    = (state == FILL);
  assign pmem_address = pmem_read ? {fill_line, 5'b0} : 32'h0;

  always_comb begin
    mem_rdata = 32'h0;
    if (idle_hit)
      mem_rdata = lines[idx][{wsel, 5'b0} +: 32];
    else if (bypass)
      mem_rdata = pmem_rdata[{wsel, 5'b0} +: 32];
  end

  // Control state; the miss flag remembers that the pending response came from a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      miss      <= 1'b0;
      fill_line <= '0;
    end else begin
      if (mem_resp)
        miss <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read && !lookup_hit) begin
            fill_line <= mem_address[31:5];
            miss      <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      lines[fill_idx] <= pmem_rdata;
      tags[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_l1i_cache.sv
// Self-checking bench for l1i_cache: directed scenarios plus random fetches against a set-indexed line model.
module tb_l1i_cache;

  localparam int S_INDEX = 3;
  localparam int SETS    = 1 << S_INDEX;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0;
  logic [31:0]  mem_address = 32'h0;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         l1i_hit;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model: which line address each set holds, its data, and whether a fill response is still owed.
  bit           mvalid [SETS];
  logic [31:0]  mline  [SETS];
  logic [255:0] mdata  [SETS];
  bit           mflag;

  l1i_cache #(.S_INDEX(S_INDEX)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_read(mem_read),
    .mem_address(mem_address),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .l1i_hit(l1i_hit),
    .pmem_read(pmem_read),
    .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

`ifndef L1I_CRITICAL_WORD_BYPASS_EN
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (mem_resp && pmem_read) begin
        bad++;
        $display("[TB] FAIL resp_vs_fill got both high exp not both at %0t", $time);
      end
    end
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    mflag = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    pmem_resp = 1'b0;
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One complete fetch of address a; a miss waits dly extra cycles before the fill returns.
  task automatic do_fetch(input logic [31:0] a, input int dly, input bit use_d, input logic [255:0] fd);
    logic [31:0]  line_a;
    logic [31:0]  w;
    logic [255:0] d;
    int           set;
    int           wi;
    line_a = {a[31:5], 5'b0};
    set    = int'((a >> 5) & (SETS - 1));
    wi     = int'(a[4:2]);
    mem_read    = 1'b1;
    mem_address = a;
    @(negedge clk);
    if (mvalid[set] && mline[set] == line_a) begin
      w = mdata[set][wi*32 +: 32];
      total++;
      if ({mem_resp, l1i_hit, mem_rdata} !== {1'b1, !mflag, w}) begin
        bad++;
        $display("[TB] FAIL hit_resp addr=%h got resp/hit/data=%b/%b/%h exp=1/%b/%h",
                 a, mem_resp, l1i_hit, mem_rdata, !mflag, w);
      end
      mflag = 1'b0;
      tick();
      mem_read = 1'b0;
    end else begin
      total++;
      if ({mem_resp, pmem_read} !== 2'b00) begin
        bad++;
        $display("[TB] FAIL miss_lookup addr=%h got resp/pread=%b/%b exp=0/0", a, mem_resp, pmem_read);
      end
      mflag = 1'b1;
      tick();
      @(negedge clk);
      total++;
      if ({pmem_read, pmem_address, mem_resp} !== {1'b1, line_a, 1'b0}) begin
        bad++;
        $display("[TB] FAIL fill_req addr=%h got pread/paddr/resp=%b/%h/%b exp=1/%h/0",
                 a, pmem_read, pmem_address, mem_resp, line_a);
      end
      for (int i = 0; i < dly; i++) begin
        tick();
        @(negedge clk);
        total++;
        if ({pmem_read, pmem_address} !== {1'b1, line_a}) begin
          bad++;
          $display("[TB] FAIL fill_hold addr=%h got pread/paddr=%b/%h exp=1/%h", a, pmem_read, pmem_address, line_a);
        end
      end
      tick();
      d = use_d ? fd : rand_line();
      pmem_resp  = 1'b1;
      pmem_rdata = d;
      w = d[wi*32 +: 32];
      mvalid[set] = 1'b1;
      mline[set]  = line_a;
      mdata[set]  = d;
      @(negedge clk);
`ifdef L1I_CRITICAL_WORD_BYPASS_EN
      total++;
      if ({mem_resp, l1i_hit, mem_rdata} !== {1'b1, 1'b0, w}) begin
        bad++;
        $display("[TB] FAIL bypass_resp addr=%h got resp/hit/data=%b/%b/%h exp=1/0/%h",
                 a, mem_resp, l1i_hit, mem_rdata, w);
      end
      mflag = 1'b0;
      tick();
      pmem_resp = 1'b0;
      mem_read  = 1'b0;
`else
      total++;
      if (mem_resp !== 1'b0) begin
        bad++;
        $display("[TB] FAIL fill_cycle_resp addr=%h got %b exp 0", a, mem_resp);
      end
      tick();
      pmem_resp = 1'b0;
      @(negedge clk);
      total++;
      if ({mem_resp, l1i_hit, mem_rdata} !== {1'b1, 1'b0, w}) begin
        bad++;
        $display("[TB] FAIL miss_resp addr=%h got resp/hit/data=%b/%b/%h exp=1/0/%h",
                 a, mem_resp, l1i_hit, mem_rdata, w);
      end
      mflag = 1'b0;
      tick();
      mem_read = 1'b0;
`endif
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    mem_read    = 1'b1;
    mem_address = 32'h0000_0060;
    #2;
    total++;
    if ({mem_resp, l1i_hit, pmem_read, pmem_address, mem_rdata} !== 67'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got resp/hit/pread/paddr/data=%b/%b/%b/%h/%h exp all zero",
               mem_resp, l1i_hit, pmem_read, pmem_address, mem_rdata);
    end
    apply_reset();
  endtask

  task automatic test_directed();
    logic [255:0] d;
    d = rand_line();
    d[127:96] = 32'h00A0_0093;
    do_fetch(32'h0000_006C, 5, 1'b1, d);
    total++;
    if (mdata[3][127:96] !== 32'h00A0_0093) begin
      bad++;
      $display("[TB] FAIL directed_model got %h exp 00a00093", mdata[3][127:96]);
    end
    do_fetch(32'h0000_006C, 0, 1'b0, '0);
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_0160, 2, 1'b0, '0);
    do_fetch(32'h0000_0060, 1, 1'b0, '0);
    do_fetch(32'h0000_0064, 0, 1'b0, '0);
  endtask

  task automatic test_addr_change();
    logic [255:0] d;
    apply_reset();
    mem_read    = 1'b1;
    mem_address = 32'h0000_0080;
    @(negedge clk);
    total++;
    if (mem_resp !== 1'b0) begin
      bad++;
      $display("[TB] FAIL chg_lookup got %b exp 0", mem_resp);
    end
    tick();
    mem_address = 32'h0000_0100;
    @(negedge clk);
    total++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0080}) begin
      bad++;
      $display("[TB] FAIL chg_paddr got %b/%h exp 1/00000080", pmem_read, pmem_address);
    end
    tick();
    d = rand_line();
    pmem_resp  = 1'b1;
    pmem_rdata = d;
    mvalid[4] = 1'b1;
    mline[4]  = 32'h0000_0080;
    mdata[4]  = d;
    mflag     = 1'b1;
    @(negedge clk);
    total++;
    if ({pmem_address, mem_resp} !== {32'h0000_0080, 1'b0}) begin
      bad++;
      $display("[TB] FAIL chg_fill got paddr/resp=%h/%b exp 00000080/0", pmem_address, mem_resp);
    end
    tick();
    pmem_resp = 1'b0;
    do_fetch(32'h0000_0100, 1, 1'b0, '0);
    do_fetch(32'h0000_0088, 0, 1'b0, '0);
  endtask

  task automatic test_drop_read();
    logic [255:0] d;
    mem_read    = 1'b1;
    mem_address = 32'h0000_1040;
    @(negedge clk);
    total++;
    if (mem_resp !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drop_lookup got %b exp 0", mem_resp);
    end
    tick();
    mem_read = 1'b0;
    @(negedge clk);
    total++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_1040}) begin
      bad++;
      $display("[TB] FAIL drop_fill got %b/%h exp 1/00001040", pmem_read, pmem_address);
    end
    tick();
    d = rand_line();
    pmem_resp  = 1'b1;
    pmem_rdata = d;
    mvalid[2] = 1'b1;
    mline[2]  = 32'h0000_1040;
    mdata[2]  = d;
    mflag     = 1'b1;
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_resp, pmem_read} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL drop_idle got resp/pread=%b/%b exp 0/0", mem_resp, pmem_read);
    end
    tick();
    do_fetch(32'h0000_1044, 0, 1'b0, '0);
    do_fetch(32'h0000_1048, 0, 1'b0, '0);
  endtask

  task automatic test_pmem_resp_idle();
    pmem_resp  = 1'b1;
    pmem_rdata = rand_line();
    @(negedge clk);
    total++;
    if ({pmem_read, mem_resp} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL stray_resp got pread/resp=%b/%b exp 0/0", pmem_read, mem_resp);
    end
    tick();
    pmem_resp = 1'b0;
    do_fetch(32'h0000_05E0, 0, 1'b0, '0);
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    mem_read    = 1'b1;
    mem_address = 32'h0000_0080;
    tick();
    @(negedge clk);
    total++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0080}) begin
      bad++;
      $display("[TB] FAIL rst_fill_req got %b/%h exp 1/00000080", pmem_read, pmem_address);
    end
    tick();
    rst_n    = 1'b0;
    mem_read = 1'b0;
    clear_model();
    #1;
    total++;
    if ({pmem_read, pmem_address, mem_resp, l1i_hit} !== 35'h0) begin
      bad++;
      $display("[TB] FAIL rst_abort got pread/paddr/resp/hit=%b/%h/%b/%b exp all zero",
               pmem_read, pmem_address, mem_resp, l1i_hit);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = rand_line();
    @(negedge clk);
    total++;
    if ({pmem_read, mem_resp} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rst_late_resp got pread/resp=%b/%b exp 0/0", pmem_read, mem_resp);
    end
    tick();
    pmem_resp = 1'b0;
    do_fetch(32'h0000_0080, 1, 1'b0, '0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, SETS - 1) << 5)
        | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      do_fetch(a, int'($urandom_range(0, 4)), 1'b0, '0);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_directed();
    test_conflict();
    test_addr_change();
    test_drop_read();
    test_pmem_resp_idle();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
